// File: rtl/recovery_rom_arbiter.sv
// Two-core arbiter in front of the single-ported recovery code ROM.
// Round-robin grant, window/alignment check on the granted address, and a
// one-deep response register that steers the 1-cycle-latency ROM data back
// to the core that issued the access.
module recovery_rom_arbiter #(
    parameter logic [31:0] ROM_BASE = 32'h00040080,
    parameter int unsigned ROM_SIZE = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core0_req_i,
    input  logic [31:0] core0_addr_i,
    output logic        core0_gnt_o,
    output logic        core0_rvalid_o,
    output logic [31:0] core0_rdata_o,
    output logic        core0_err_o,
    input  logic        core1_req_i,
    input  logic [31:0] core1_addr_i,
    output logic        core1_gnt_o,
    output logic        core1_rvalid_o,
    output logic [31:0] core1_rdata_o,
    output logic        core1_err_o,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_rdata_i
);

    // Window bounds in 33 bits so the upper bound never wraps.
    localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [32:0] ROM_HI = ROM_LO + 33'(ROM_SIZE);

    logic [1:0]  req;
    logic [31:0] addr [2];

    logic        grant_any;
    logic        grant_id;
    logic [31:0] grant_addr;
    logic        in_range;

    logic        last_grant_reg, last_grant_next;
    logic        resp_valid_reg, resp_valid_next;
    logic        resp_id_reg,    resp_id_next;
    logic        resp_err_reg,   resp_err_next;

    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [31:0] rdata [2];

    assign req     = {core1_req_i, core0_req_i};
    assign addr[0] = core0_addr_i;
    assign addr[1] = core1_addr_i;

    // Round-robin pick: a lone requester always wins, contention goes to the
    // core that was not granted last. Nothing is granted while in reset.
    always_comb begin
        grant_any = (|req) && !rst_i;
        if (&req) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = req[1];
        end
        grant_addr = addr[grant_id];
    end

    // Window and word-alignment check on the granted address.
    always_comb begin
        in_range = ({1'b0, grant_addr} >= ROM_LO) &&
                   ({1'b0, grant_addr} <  ROM_HI) &&
                   (grant_addr[1:0] == 2'b00);
    end

    // Only legal accesses reach the ROM; the address bus is parked at 0 otherwise.
    always_comb begin
        rom_req_o  = grant_any && in_range;
        rom_addr_o = rom_req_o ? grant_addr : 32'h0;
    end

    // Next state: remember who was granted and what the response will be.
    always_comb begin
        last_grant_next = last_grant_reg;
        resp_valid_next = 1'b0;
        resp_id_next    = resp_id_reg;
        resp_err_next   = resp_err_reg;
        if (grant_any) begin
            last_grant_next = grant_id;
            resp_valid_next = 1'b1;
            resp_id_next    = grant_id;
            resp_err_next   = !in_range;
        end
    end

    // State registers; last_grant resets to core 1 so core 0 wins first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_reg <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
            resp_valid_reg <= resp_valid_next;
            resp_id_reg    <= resp_id_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    // Per-core grant and response steering; a response in flight is dropped
    // while reset is asserted, and data never leaks to the other core.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_core
            assign gnt[gi]    = grant_any && (grant_id == 1'(gi));
            assign rvalid[gi] = resp_valid_reg && !rst_i && (resp_id_reg == 1'(gi));
            assign err[gi]    = rvalid[gi] && resp_err_reg;
            assign rdata[gi]  = (rvalid[gi] && !resp_err_reg) ? rom_rdata_i : 32'h0;
        end
    endgenerate

    assign core0_gnt_o    = gnt[0];
    assign core0_rvalid_o = rvalid[0];
    assign core0_err_o    = err[0];
    assign core0_rdata_o  = rdata[0];
    assign core1_gnt_o    = gnt[1];
    assign core1_rvalid_o = rvalid[1];
    assign core1_err_o    = err[1];
    assign core1_rdata_o  = rdata[1];

endmodule

// File: tb/tb_recovery_rom_arbiter.sv
// Bench for recovery_rom_arbiter: directed vector table followed by random
// traffic checked against a transaction-level model of the arbiter.
module tb_recovery_rom_arbiter;

    localparam logic [31:0] BASE = 32'h00040080;
    localparam int unsigned SIZE = 256;

    logic        clk;
    logic        rst;
    logic        r0, r1;
    logic [31:0] a0, a1;
    logic        g0, g1, rv0, rv1, e0, e1;
    logic [31:0] d0, d1;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        bit          r0;
        logic [31:0] a0;
        bit          r1;
        logic [31:0] a1;
        logic [1:0]  gnt;      // bit0 = core 0
        bit          rreq;
        logic [31:0] raddr;
        bit          rv0;
        bit          e0;
        logic [31:0] d0;
        bit          rv1;
        bit          e1;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl[$];

    // Model state: who was granted last, and the one outstanding response.
    bit          m_last;
    bit          m_pv;
    bit          m_pid;
    bit          m_perr;
    logic [31:0] m_paddr;

    recovery_rom_arbiter #(.ROM_BASE(BASE), .ROM_SIZE(SIZE)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .core0_req_i   (r0),
        .core0_addr_i  (a0),
        .core0_gnt_o   (g0),
        .core0_rvalid_o(rv0),
        .core0_rdata_o (d0),
        .core0_err_o   (e0),
        .core1_req_i   (r1),
        .core1_addr_i  (a1),
        .core1_gnt_o   (g1),
        .core1_rvalid_o(rv1),
        .core1_rdata_o (d1),
        .core1_err_o   (e1),
        .rom_req_o     (rom_req),
        .rom_addr_o    (rom_addr),
        .rom_rdata_i   (rom_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hC0, b, ~b, 8'(i * 7)};
    endfunction

    // ROM stand-in: 1-cycle read latency, garbage on cycles without a read.
    always @(posedge clk) begin
        if (rom_req) rom_rdata <= rom_word(int'((rom_addr - BASE) >> 2) & 63);
        else         rom_rdata <= $urandom;
    end

    function automatic bit legal(logic [31:0] a);
        longint unsigned x;
        x = a;
        return (x >= BASE) && (x < longint'(BASE) + SIZE) && (x % 4 == 0);
    endfunction

    function automatic vec_t mk(bit rs, bit q0, logic [31:0] x0, bit q1, logic [31:0] x1,
                                logic [1:0] gn, bit rq, logic [31:0] ra,
                                bit v0, bit er0, logic [31:0] y0,
                                bit v1, bit er1, logic [31:0] y1);
        vec_t v;
        v.rst = rs; v.r0 = q0; v.a0 = x0; v.r1 = q1; v.a1 = x1;
        v.gnt = gn; v.rreq = rq; v.raddr = ra;
        v.rv0 = v0; v.e0 = er0; v.d0 = y0;
        v.rv1 = v1; v.e1 = er1; v.d1 = y1;
        return v;
    endfunction

    // Fill in the expected outputs of v from the model's view of the rules.
    function automatic vec_t model_expect(vec_t v);
        vec_t o;
        bit   winner;
        bit   ok;
        o = v;
        o.gnt = 2'b00; o.rreq = 0; o.raddr = 0;
        o.rv0 = 0; o.e0 = 0; o.d0 = 0; o.rv1 = 0; o.e1 = 0; o.d1 = 0;
        if (!v.rst) begin
            if (m_pv) begin
                if (m_pid == 0) begin
                    o.rv0 = 1; o.e0 = m_perr;
                    o.d0 = m_perr ? 32'h0 : rom_word(int'((m_paddr - BASE) / 4));
                end else begin
                    o.rv1 = 1; o.e1 = m_perr;
                    o.d1 = m_perr ? 32'h0 : rom_word(int'((m_paddr - BASE) / 4));
                end
            end
            if (v.r0 || v.r1) begin
                winner = (v.r0 && v.r1) ? !m_last : v.r1;
                o.gnt[winner] = 1'b1;
                ok = legal(winner ? v.a1 : v.a0);
                if (ok) begin
                    o.rreq  = 1;
                    o.raddr = winner ? v.a1 : v.a0;
                end
            end
        end
        return o;
    endfunction

    // Advance the model by one clock given the inputs applied this cycle.
    task automatic model_step(vec_t v);
        bit winner;
        if (v.rst) begin
            m_last = 1;
            m_pv   = 0;
        end else if (v.r0 || v.r1) begin
            winner  = (v.r0 && v.r1) ? !m_last : v.r1;
            m_last  = winner;
            m_pv    = 1;
            m_pid   = winner;
            m_paddr = winner ? v.a1 : v.a0;
            m_perr  = !legal(m_paddr);
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle, sample mid-cycle, compare, then advance past the edge.
    task automatic apply(vec_t v, int idx, bit verbose);
        rst = v.rst; r0 = v.r0; a0 = v.a0; r1 = v.r1; a1 = v.a1;
        #3;
        chk("gnt",   idx, 64'({g1, g0}), 64'(v.gnt));
        chk("rom",   idx, 64'({rom_req, rom_addr}), 64'({v.rreq, v.raddr}));
        chk("resp0", idx, 64'({rv0, e0, d0}), 64'({v.rv0, v.e0, v.d0}));
        chk("resp1", idx, 64'({rv1, e1, d1}), 64'({v.rv1, v.e1, v.d1}));
        if (verbose || g0 || g1)
            $display("step %0d rst=%0b req=%0b%0b gnt=%0b%0b rom=%0b@%h rv=%0b%0b err=%0b%0b",
                     idx, v.rst, v.r1, v.r0, g1, g0, rom_req, rom_addr, rv1, rv0, e1, e0);
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   n;
        rst = 1; r0 = 0; r1 = 0; a0 = 0; a1 = 0;
        m_last = 1; m_pv = 0; m_pid = 0; m_perr = 0; m_paddr = 0;

        // Reset with a pending request, then first access after release.
        tbl.push_back(mk(1, 1, BASE, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, BASE, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, BASE, 0, 0, 2'b01, 1, BASE, 0, 0, 0, 0, 0, 0));
        // Single core 0 read of word 1.
        tbl.push_back(mk(0, 1, BASE + 4, 0, 0, 2'b01, 1, BASE + 4, 1, 0, rom_word(0), 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, rom_word(1), 0, 0, 0));
        // Continuous contention after reset alternates starting with core 0.
        tbl.push_back(mk(1, 1, BASE, 1, BASE, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(0, 1, BASE, 1, BASE, (k % 2 == 0) ? 2'b01 : 2'b10, 1, BASE,
                             (k > 0) && (k % 2 == 1), 0, ((k > 0) && (k % 2 == 1)) ? rom_word(0) : 32'h0,
                             (k > 0) && (k % 2 == 0), 0, ((k > 0) && (k % 2 == 0)) ? rom_word(0) : 32'h0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, rom_word(0)));
        // Core 1 out-of-window and misaligned reads.
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, BASE + 2, 2'b10, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0));
        // Window boundaries.
        tbl.push_back(mk(0, 1, BASE + 32'hFC, 0, 0, 2'b01, 1, BASE + 32'hFC, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, BASE + 32'h100, 0, 0, 2'b01, 0, 0, 1, 0, rom_word(63), 0, 0, 0));
        tbl.push_back(mk(0, 1, BASE - 4, 0, 0, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0));
        // Reset right after a grant drops the response and restores priority.
        tbl.push_back(mk(0, 1, BASE, 0, 0, 2'b01, 1, BASE, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, BASE, 1, BASE, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, BASE, 1, BASE, 2'b01, 1, BASE, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, rom_word(0), 0, 0, 0));

        @(posedge clk);
        #1;
        n = 0;
        foreach (tbl[i]) begin
            apply(tbl[i], n, 1'b1);
            n++;
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pick [2];
            for (int c = 0; c < 2; c++) begin
                case ($urandom_range(0, 5))
                    0: pick[c] = BASE + 4 * $urandom_range(0, 63);
                    1: pick[c] = BASE + 32'h100;
                    2: pick[c] = BASE - 4;
                    3: pick[c] = BASE + $urandom_range(0, 255);
                    4: pick[c] = $urandom;
                    default: pick[c] = 32'hFFFFFFFC;
                endcase
            end
            v = mk($urandom_range(0, 39) == 0, 1'($urandom), pick[0], 1'($urandom), pick[1],
                   0, 0, 0, 0, 0, 0, 0, 0, 0);
            v = model_expect(v);
            apply(v, n, 1'b0);
            n++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
